aclk_controller: RTL and testbench
==================================

# aclk_controller

Alarm-clock mode controller: a Moore state machine that interprets keypad digits and the alarm/time buttons. It drives the display-select strobes (`show_new_time`, `show_a`) consumed by `aclk_lcd_display`. It also drives the keypad shift register (`shift`), the alarm register load (`load_new_a`) and the time counter load/reset (`load_new_c`, `reset_count`). It sits upstream of the display stage, beside the key register, alarm register and time counter. A 10-second inactivity timeout abandons incomplete key entry.

## Interface
- `TIMEOUT_S`, default 10: seconds of keypad inactivity before key entry is abandoned; legal range 2..15.
- `NOKEY`, default 4'hA: key code meaning "no key pressed"; codes 0..9 are digits.
- `clock`  in  1: single system clock, all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `one_second`  in  1: one-cycle pulse, once per second, from the timebase.
- `alarm_button`  in  1: level, high while the alarm button is held.
- `time_button`  in  1: level, high while the time button is held.
- `key`  in  4: current keypad code, digit 0..9 or `NOKEY`; held stable while pressed.
- `show_new_time`  out  1: display the key buffer instead of the current time.
- `show_a`  out  1: display the alarm time.
- `shift`  out  1: one-cycle strobe that shifts `key` into the key buffer.
- `load_new_a`  out  1: one-cycle strobe that loads the key buffer into the alarm register.
- `load_new_c`  out  1: one-cycle strobe that loads the key buffer into the time counter.
- `reset_count`  out  1: one-cycle strobe that clears the seconds prescaler; coincident with `load_new_c`.

## Operation
- States: SHOW_TIME, KEY_STORED, KEY_WAITED, KEY_ENTRY, SHOW_ALARM, SET_ALARM_TIME, SET_CURRENT_TIME.
- Transitions; where several conditions are listed, the first that holds wins:
  - **SHOW_TIME:** `alarm_button` → SHOW_ALARM; `key`≠NOKEY → KEY_STORED; else stay.
  - **KEY_STORED:** → KEY_WAITED, unconditionally.
  - **KEY_WAITED:** `key`==NOKEY → KEY_ENTRY; timeout → SHOW_TIME; else stay (key still held).
  - **KEY_ENTRY:** `alarm_button` → SET_ALARM_TIME; `time_button` → SET_CURRENT_TIME; `key`≠NOKEY → KEY_STORED; timeout → SHOW_TIME; else stay.
  - **SHOW_ALARM:** `!alarm_button` → SHOW_TIME; else stay.
  - **SET_ALARM_TIME, SET_CURRENT_TIME:** → SHOW_TIME, unconditionally.
- Output decode (Moore, from the state register only):
  - `show_new_time` = 1 in KEY_STORED, KEY_WAITED and KEY_ENTRY.
  - `show_a` = 1 in SHOW_ALARM.
  - `shift` = 1 in KEY_STORED.
  - `load_new_a` = 1 in SET_ALARM_TIME.
  - `load_new_c` and `reset_count` = 1 in SET_CURRENT_TIME.
  - All other outputs are 0 in every state.
- `show_new_time` and `show_a` are never high together.
- Timeout counter:
  - 4-bit, saturating.
  - Cleared every cycle the state is outside {KEY_WAITED, KEY_ENTRY}.
  - Increments on `one_second` while inside that set.
  - Timeout = (count == `TIMEOUT_S`-1) && `one_second`.
  - It is not cleared on KEY_WAITED→KEY_ENTRY. It is cleared via KEY_STORED on each new digit.
- Buttons are ignored in SHOW_TIME/KEY_WAITED except where a transition above names them. Both buttons high in KEY_ENTRY selects the alarm load.
- An undefined state encoding recovers to SHOW_TIME on the next edge.

## Timing
- Reset: on the first rising edge with `reset`=1, the state becomes SHOW_TIME and the counter becomes 0. All outputs are 0 from that edge.
- Reset mid-entry discards entry with no load strobe. The key buffer contents are untouched by this block.
- Input-to-output latency is 1 cycle. A key seen at edge N gives `shift`=1 in cycle N+1, exactly one cycle long; the next digit needs release (NOKEY) first.
- A load strobe is high for exactly one cycle. SHOW_TIME (`show_new_time`=0) follows on the next cycle.
- Timeout:
  - The state leaves KEY_ENTRY/KEY_WAITED on the edge after the `TIMEOUT_S`-th `one_second` pulse counted since the last KEY_STORED.
  - The effective delay is `TIMEOUT_S`-1 to `TIMEOUT_S` seconds, depending on pulse phase.
- Simultaneous key press and timeout in KEY_ENTRY: the key wins (→ KEY_STORED, counter cleared).
- A `one_second` pulse coincident with a load strobe has no effect.

## Structure
- Shared package `aclk_defs`: `NOKEY` constant, state enumeration/localparams (3-bit encoding, SHOW_TIME=0), `TIMEOUT_S` default.
- One natural sub-module: `aclk_timeout_cnt` (clear / enable / tick → `timeout`). The FSM and output decode stay in `aclk_controller`.

## Test plan
- **Reset:** assert `reset` for 2 cycles from KEY_ENTRY → all outputs 0; state SHOW_TIME; `key`=4'hA held gives no activity.
- **Digit entry:** press 1,2,3,4, each held 3 cycles with 2-cycle NOKEY gaps → exactly 4 single-cycle `shift` pulses; `show_new_time`=1 throughout; `show_a`=0.
- **Alarm set:** after 4 digits, `alarm_button`=1 in KEY_ENTRY → `load_new_a`=1 for one cycle, then SHOW_TIME. Repeat with both buttons high → `load_new_a`, not `load_new_c`.
- **Time set:** after 4 digits, `time_button`=1 → `load_new_c`=`reset_count`=1 for one cycle; `show_new_time`=0 next cycle.
- **Timeout:** one digit, then 10 `one_second` pulses and no keys → return to SHOW_TIME after the 10th pulse. Repeat with a digit at pulse 9 → no timeout; counter restarts.
- **Show alarm:** hold `alarm_button` 5 cycles in SHOW_TIME → `show_a`=1 from cycle 2 until 1 cycle after release. A key pressed meanwhile gives no `shift`.

Source files
------------

// File: rtl/aclk_defs.sv
// Shared definitions for the alarm-clock mode controller.
// Holds the key code, state encoding, timeout default and output decode.
package aclk_defs;

  localparam int unsigned STATE_W       = 3;
  localparam int unsigned CNT_W         = 4;
  localparam int unsigned KEY_W         = 4;
  localparam int unsigned TIMEOUT_S_DEF = 10;

  localparam logic [KEY_W-1:0] NOKEY_DEF = 4'hA;

  localparam logic [STATE_W-1:0] SHOW_TIME        = 3'd0;
  localparam logic [STATE_W-1:0] KEY_STORED       = 3'd1;
  localparam logic [STATE_W-1:0] KEY_WAITED       = 3'd2;
  localparam logic [STATE_W-1:0] KEY_ENTRY        = 3'd3;
  localparam logic [STATE_W-1:0] SHOW_ALARM       = 3'd4;
  localparam logic [STATE_W-1:0] SET_ALARM_TIME   = 3'd5;
  localparam logic [STATE_W-1:0] SET_CURRENT_TIME = 3'd6;

  typedef struct packed {
    logic show_new_time;
    logic show_a;
    logic shift;
    logic load_new_a;
    logic load_new_c;
    logic reset_count;
  } ctl_out_t;

  // Moore output decode for a given state; unused encodings give all zeros.
  function automatic ctl_out_t ctl_decode(input logic [STATE_W-1:0] s);
    ctl_out_t o;
    o = '0;
    case (s)
      KEY_STORED: begin
        o.show_new_time = 1'b1;
        o.shift         = 1'b1;
      end
      KEY_WAITED, KEY_ENTRY: o.show_new_time = 1'b1;
      SHOW_ALARM:            o.show_a        = 1'b1;
      SET_ALARM_TIME:        o.load_new_a    = 1'b1;
      SET_CURRENT_TIME: begin
        o.load_new_c  = 1'b1;
        o.reset_count = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/aclk_controller_if.sv
// Keypad/button inputs and control strobes between the timebase/keypad side and the controller.
interface aclk_controller_if;

  logic                        one_second;
  logic                        alarm_button;
  logic                        time_button;
  logic [aclk_defs::KEY_W-1:0] key;
  logic                        show_new_time;
  logic                        show_a;
  logic                        shift;
  logic                        load_new_a;
  logic                        load_new_c;
  logic                        reset_count;

  modport master (
    output one_second, alarm_button, time_button, key,
    input  show_new_time, show_a, shift, load_new_a, load_new_c, reset_count
  );

  modport slave (
    input  one_second, alarm_button, time_button, key,
    output show_new_time, show_a, shift, load_new_a, load_new_c, reset_count
  );

endinterface

// File: rtl/aclk_timeout_cnt.sv
// Saturating seconds counter for keypad inactivity; flags the TIMEOUT_S-th tick.
module aclk_timeout_cnt
  import aclk_defs::*;
#(
  parameter int unsigned TIMEOUT_S = TIMEOUT_S_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic tick,
  output logic timeout_c
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable && tick && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign timeout_c = enable && tick && (cnt_q == CNT_W'(TIMEOUT_S - 1));

endmodule

// File: rtl/aclk_controller.sv
// Alarm-clock mode controller: interprets digits and buttons, drives display
// selects and load strobes. Outputs are registered from the next-state decode.
module aclk_controller
  import aclk_defs::*;
#(
  parameter int unsigned      TIMEOUT_S = TIMEOUT_S_DEF,
  parameter logic [KEY_W-1:0] NOKEY     = NOKEY_DEF
) (
  input logic              clock,
  input logic              reset,
  aclk_controller_if.slave bus
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  ctl_out_t           out_q;
  logic               in_wait;
  logic               timeout_c;
  logic               key_down;

  assign in_wait  = (state_q == KEY_WAITED) || (state_q == KEY_ENTRY);
  assign key_down = (bus.key != NOKEY);

  aclk_timeout_cnt #(
    .TIMEOUT_S (TIMEOUT_S)
  ) u_timeout_cnt (
    .clock     (clock),
    .reset     (reset),
    .clear     (!in_wait),
    .enable    (in_wait),
    .tick      (bus.one_second),
    .timeout_c (timeout_c)
  );

  // State and registered Moore outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SHOW_TIME;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= ctl_decode(state_d);
    end
  end

  // Next-state selection; earlier conditions take priority.
  always_comb begin
    state_d = SHOW_TIME;
    case (state_q)
      SHOW_TIME: begin
        if (bus.alarm_button)  state_d = SHOW_ALARM;
        else if (key_down)     state_d = KEY_STORED;
        else                   state_d = SHOW_TIME;
      end
      KEY_STORED:              state_d = KEY_WAITED;
      KEY_WAITED: begin
        if (!key_down)         state_d = KEY_ENTRY;
        else if (timeout_c)    state_d = SHOW_TIME;
        else                   state_d = KEY_WAITED;
      end
      KEY_ENTRY: begin
        if (bus.alarm_button)     state_d = SET_ALARM_TIME;
        else if (bus.time_button) state_d = SET_CURRENT_TIME;
        else if (key_down)        state_d = KEY_STORED;
        else if (timeout_c)       state_d = SHOW_TIME;
        else                      state_d = KEY_ENTRY;
      end
      SHOW_ALARM: begin
        if (!bus.alarm_button) state_d = SHOW_TIME;
        else                   state_d = SHOW_ALARM;
      end
      SET_ALARM_TIME, SET_CURRENT_TIME: state_d = SHOW_TIME;
      default:                          state_d = SHOW_TIME;
    endcase
  end

  assign bus.show_new_time = out_q.show_new_time;
  assign bus.show_a        = out_q.show_a;
  assign bus.shift         = out_q.shift;
  assign bus.load_new_a    = out_q.load_new_a;
  assign bus.load_new_c    = out_q.load_new_c;
  assign bus.reset_count   = out_q.reset_count;

endmodule

// File: tb/tb_aclk_controller.sv
// Bench for aclk_controller: directed vector table, timeout/show-alarm
// sequences and randomized traffic against a behavioural model.
module tb_aclk_controller;

  localparam int unsigned TO_S  = 10;
  localparam logic [3:0]  NOKEY = 4'hA;

  logic clock;
  logic reset;

  aclk_controller_if bus ();

  aclk_controller #(
    .TIMEOUT_S (TO_S),
    .NOKEY     (NOKEY)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  // Behavioural model: entry session, held key, one-cycle events, seconds since last digit.
  bit entry_active, held, shift_pend, alarm_view;
  int strobe;  // 0 none, 1 alarm load, 2 time load
  int secs;

  function automatic logic [5:0] model_out();
    return {entry_active, alarm_view, shift_pend, strobe == 1, strobe == 2, strobe == 2};
  endfunction

  task automatic model_step(input bit r, input bit os, input bit ab, input bit tb, input logic [3:0] k);
    bit timed_out;
    if (r) begin
      entry_active = 0; held = 0; shift_pend = 0; alarm_view = 0; strobe = 0; secs = 0;
    end else if (strobe != 0) begin
      strobe = 0;
    end else if (shift_pend) begin
      shift_pend = 0; held = 1; secs = 0;
    end else if (alarm_view) begin
      alarm_view = ab;
    end else if (!entry_active) begin
      if (ab) alarm_view = 1;
      else if (k != NOKEY) begin entry_active = 1; shift_pend = 1; secs = 0; end
    end else begin
      timed_out = os && (secs + 1 >= int'(TO_S));
      if (os) secs = secs + 1;
      if (held) begin
        if (k == NOKEY) held = 0;
        else if (timed_out) entry_active = 0;
      end else begin
        if (ab)              begin entry_active = 0; strobe = 1; end
        else if (tb)         begin entry_active = 0; strobe = 2; end
        else if (k != NOKEY) begin shift_pend = 1; secs = 0; end
        else if (timed_out)  entry_active = 0;
      end
    end
  endtask

  function automatic logic [5:0] dut_out();
    return {bus.show_new_time, bus.show_a, bus.shift, bus.load_new_a, bus.load_new_c, bus.reset_count};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b (snt,sa,shift,lda,ldc,rc) at %0t", name, act, exp, $time);
  endtask

  // One clock: drive on negedge, model on posedge, sample 1 time unit later.
  task automatic cycle(input bit r, input bit os, input bit ab, input bit tb, input logic [3:0] k,
                       input string name);
    @(negedge clock);
    reset = r; bus.one_second = os; bus.alarm_button = ab; bus.time_button = tb; bus.key = k;
    @(posedge clock);
    model_step(r, os, ab, tb, k);
    #1;
    check(name, dut_out(), model_out());
  endtask

  typedef struct {
    bit         r;
    bit         ab;
    bit         tb;
    logic [3:0] k;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[30];

  task automatic set_vec(input int i, input bit r, input bit ab, input bit tb, input logic [3:0] k,
                         input logic [5:0] exp);
    vecs[i].r = r; vecs[i].ab = ab; vecs[i].tb = tb; vecs[i].k = k; vecs[i].exp = exp;
  endtask

  initial begin
    reset = 1'b1;
    bus.one_second = 1'b0; bus.alarm_button = 1'b0; bus.time_button = 1'b0; bus.key = NOKEY;

    // Expected columns: show_new_time, show_a, shift, load_new_a, load_new_c, reset_count.
    set_vec( 0, 1, 0, 0, 4'hA, 6'b000000);
    set_vec( 1, 1, 0, 0, 4'hA, 6'b000000);
    set_vec( 2, 0, 0, 0, 4'hA, 6'b000000);
    set_vec( 3, 0, 0, 0, 4'h1, 6'b101000);
    set_vec( 4, 0, 0, 0, 4'h1, 6'b100000);
    set_vec( 5, 0, 0, 0, 4'h1, 6'b100000);
    set_vec( 6, 0, 0, 0, 4'hA, 6'b100000);
    set_vec( 7, 0, 0, 0, 4'hA, 6'b100000);
    set_vec( 8, 0, 0, 0, 4'h2, 6'b101000);
    set_vec( 9, 0, 0, 0, 4'h2, 6'b100000);
    set_vec(10, 0, 0, 0, 4'hA, 6'b100000);
    set_vec(11, 0, 1, 0, 4'hA, 6'b000100);
    set_vec(12, 0, 0, 0, 4'hA, 6'b000000);
    set_vec(13, 0, 0, 0, 4'h3, 6'b101000);
    set_vec(14, 0, 0, 0, 4'hA, 6'b100000);
    set_vec(15, 0, 0, 0, 4'hA, 6'b100000);
    set_vec(16, 0, 1, 1, 4'hA, 6'b000100);
    set_vec(17, 0, 0, 0, 4'hA, 6'b000000);
    set_vec(18, 0, 0, 0, 4'h5, 6'b101000);
    set_vec(19, 0, 0, 0, 4'hA, 6'b100000);
    set_vec(20, 0, 0, 0, 4'hA, 6'b100000);
    set_vec(21, 0, 0, 1, 4'hA, 6'b000011);
    set_vec(22, 0, 0, 0, 4'hA, 6'b000000);
    set_vec(23, 0, 1, 0, 4'hA, 6'b010000);
    set_vec(24, 0, 1, 0, 4'h7, 6'b010000);
    set_vec(25, 0, 0, 0, 4'h7, 6'b000000);
    set_vec(26, 0, 0, 0, 4'h7, 6'b101000);
    set_vec(27, 0, 0, 0, 4'hA, 6'b100000);
    set_vec(28, 1, 0, 0, 4'hA, 6'b000000);
    set_vec(29, 0, 0, 0, 4'hA, 6'b000000);

    for (int i = 0; i < 30; i++) begin
      cycle(vecs[i].r, 1'b0, vecs[i].ab, vecs[i].tb, vecs[i].k, $sformatf("model_vec%0d", i));
      check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
    end

    // Four digits held 3 cycles with 2-cycle gaps: exactly four shift pulses.
    begin
      int shifts = 0;
      bit snt_ok = 1;
      for (int d = 1; d <= 4; d++) begin
        for (int c = 0; c < 3; c++) begin
          cycle(0, 0, 0, 0, 4'(d), "digits");
          shifts += int'(bus.shift);
          snt_ok &= bus.show_new_time & ~bus.show_a;
        end
        for (int c = 0; c < 2; c++) begin
          cycle(0, 0, 0, 0, NOKEY, "digits_gap");
          shifts += int'(bus.shift);
          snt_ok &= bus.show_new_time & ~bus.show_a;
        end
      end
      check("shift_count", 6'(shifts), 6'd4);
      check("snt_during_entry", {5'b0, snt_ok}, 6'b000001);
      cycle(0, 0, 0, 1, NOKEY, "time_load");
      check("time_load", dut_out(), 6'b000011);
      cycle(0, 0, 0, 0, NOKEY, "after_time_load");
      check("after_time_load", dut_out(), 6'b000000);
    end

    // Timeout: one digit, then ten second pulses, one every three cycles.
    cycle(0, 0, 0, 0, 4'h4, "to_digit");
    cycle(0, 0, 0, 0, NOKEY, "to_release");
    for (int p = 1; p <= 10; p++) begin
      cycle(0, 0, 0, 0, NOKEY, "to_idle");
      cycle(0, 0, 0, 0, NOKEY, "to_idle");
      cycle(0, 1, 0, 0, NOKEY, "to_pulse");
      if (p == 9)  check("to_before_10th", dut_out(), 6'b100000);
      if (p == 10) check("to_after_10th", dut_out(), 6'b000000);
    end

    // A digit arriving with pulse 9 wins over the count and restarts it.
    cycle(0, 0, 0, 0, 4'h6, "rs_digit");
    cycle(0, 0, 0, 0, NOKEY, "rs_release");
    for (int p = 1; p <= 8; p++) begin
      cycle(0, 0, 0, 0, NOKEY, "rs_idle");
      cycle(0, 1, 0, 0, NOKEY, "rs_pulse");
    end
    cycle(0, 1, 0, 0, 4'h8, "rs_key_at_9");
    check("rs_key_at_9", dut_out(), 6'b101000);
    cycle(0, 0, 0, 0, NOKEY, "rs_release2");
    for (int p = 1; p <= 10; p++) begin
      cycle(0, 1, 0, 0, NOKEY, "rs_pulse2");
      if (p == 9)  check("rs_no_early_to", dut_out(), 6'b100000);
      if (p == 10) check("rs_to_after_restart", dut_out(), 6'b000000);
    end

    // Show alarm held 5 cycles with a key pressed meanwhile.
    for (int c = 1; c <= 5; c++) begin
      cycle(0, 0, 1, 0, (c == 3) ? 4'h2 : NOKEY, "sa_hold");
      check("sa_hold", dut_out(), 6'b010000);
    end
    cycle(0, 0, 0, 0, NOKEY, "sa_release");
    check("sa_release", dut_out(), 6'b000000);

    // Reset from KEY_ENTRY for two cycles.
    cycle(0, 0, 0, 0, 4'h9, "rst_digit");
    cycle(0, 0, 0, 0, NOKEY, "rst_wait");
    cycle(0, 0, 0, 0, NOKEY, "rst_entry");
    cycle(1, 0, 0, 1, NOKEY, "rst_1");
    check("rst_1", dut_out(), 6'b000000);
    cycle(1, 0, 1, 0, NOKEY, "rst_2");
    check("rst_2", dut_out(), 6'b000000);
    cycle(0, 0, 0, 0, NOKEY, "rst_idle");
    check("rst_idle", dut_out(), 6'b000000);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit r, os, ab, tb;
      logic [3:0] k;
      r  = ($urandom_range(0, 299) == 0);
      os = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 7) == 0);
      tb = ($urandom_range(0, 7) == 0);
      k  = ($urandom_range(0, 9) < 6) ? NOKEY : 4'($urandom_range(0, 9));
      cycle(r, os, ab, tb, k, "random");
      if (bus.show_new_time && bus.show_a) check("excl_displays", dut_out(), model_out() & 6'b101111);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
